regfile_wr_arbiter: RTL
=======================

# regfile_wr_arbiter

Round-robin arbiter that shares the register file's single write port between NREQ requesters. Each requester presents a valid/ready write request (address, data, optional burst lock). The block grants one requester at a time and drives a registered write strobe, address and data into the register file. It also produces the one-hot row select through the 3-to-8 write decoder, gated by the write strobe.

## Interface
- NREQ, 4, number of requesters (2..8)
- DATA_W, 8, register data width
- MAX_BURST, 4, max beats a locked requester may hold the port (>=1; 1 disables locking)
- clk  in  1  clock; all state updates on rising edge
- rst  in  1  reset, synchronous, active-high
- req_valid  in  NREQ  per-requester write request valid
- req_lock  in  NREQ  per-requester request to hold the grant for following beats
- req_addr  in  NREQ*3  per-requester register address, requester i at [3i+2:3i]
- req_data  in  NREQ*DATA_W  per-requester write data
- req_ready  out  NREQ  per-requester accept; at most one bit set
- wr_en  out  1  register file write strobe
- wr_addr  out  3  register file write address
- wr_data  out  DATA_W  register file write data
- wr_sel  out  8  one-hot row select; all zero when wr_en=0
- grant_id  out  clog2(NREQ)  index of requester whose beat is on wr_*

## Operation
- A beat transfers on requester i when req_valid[i] && req_ready[i]. req_ready is combinational from state and req_valid.
- State ARB:
  - Winner is the first valid requester scanning ptr, ptr+1, … mod NREQ.
  - req_ready[winner]=1, all other bits 0. No valid requester: req_ready=0.
  - On transfer: ptr <= winner+1 mod NREQ.
  - If req_lock[winner]=1 and MAX_BURST>1: go to BURST, with owner <= winner and beats <= 1.
- State BURST:
  - req_ready[owner]=req_valid[owner]; all other bits 0.
  - On transfer: beats++. If req_lock[owner]=0 or beats+1==MAX_BURST, return to ARB; the beat is still written.
  - Owner drops req_valid: return to ARB next cycle with no transfer.
  - ptr stays owner+1 throughout BURST.
- Output stage, every cycle:
  - wr_en <= transfer occurred.
  - On a transfer, wr_addr, wr_data and grant_id load from the accepted requester. Otherwise they hold their values.
- wr_sel = decoder(wr_addr) when wr_en=1, else 0.
- Requests to the same address in consecutive beats are written in grant order; the last write wins.

## Timing
- Reset values: state=ARB, ptr=0, beats=0, owner=0, wr_en=0, wr_addr=0, wr_data=0, grant_id=0, wr_sel=0.
- req_ready is forced to 0 while rst=1, including when rst is asserted mid-BURST. The first grant after reset goes to the lowest valid index.
- Latency: the beat accepted in cycle t appears on wr_en/wr_addr/wr_data in cycle t+1. Sustained throughput is one write per cycle.
- Boundaries:
  - All requesters continuously valid: grants go 0,1,2,…,NREQ-1,0.
  - Lock with MAX_BURST=1 is ignored.
  - Burst at the cap: the MAX_BURST-th beat is accepted, then ARB resumes on the next cycle.
  - ptr wraps NREQ-1 -> 0.

## Structure
- Package regfile_arb_pkg: state enum (ARB, BURST) and the REG_ADDR_W=3 constant.
- Sub-module rr_pick: combinational round-robin first-one finder. Inputs are the valid mask and ptr; outputs are the winner index and a found flag.
- wr_sel comes from an instance of the existing Decoder3to8 with E=wr_en and A=wr_addr.
- The rest lives in the top module: FSM, ptr/owner/beats registers, and the output registers.

## Test plan
- Reset, then req_valid=4'b1111, lock=0 for 8 cycles -> grant_id sequence 0,1,2,3,0,1,2,3 one cycle after each accept; wr_en=1 every cycle.
- Only requester 2 valid, addr=5, data=8'hA5 -> req_ready=4'b0100 and next cycle wr_en=1, wr_addr=5, wr_sel=8'h20, wr_data=8'hA5.
- Requester 1 locks with valid continuously, others valid -> exactly 4 consecutive beats from 1, then grant to 2.
- Requester 0 locks, then drops valid after 2 beats -> ARB the following cycle, next grant to 1; no wr_en during the drop cycle.
- rst asserted mid-BURST -> next cycle wr_en=0 and req_ready=0; after release, the lowest valid index wins.
- No requests for 5 cycles after traffic -> wr_en=0, wr_sel=0, wr_addr/wr_data hold their last values.

Source files
------------

// File: rtl/regfile_arb_pkg.sv
// rtl/regfile_arb_pkg.sv - shared types and constants for the register file write arbiter
package regfile_arb_pkg;

   localparam int REG_ADDR_W = 3;

   typedef enum logic {
      ARB   = 1'b0,
      BURST = 1'b1
   } arb_state_t;

endpackage

// File: rtl/decoder3to8.sv
// rtl/decoder3to8.sv - enabled 3-to-8 one-hot decoder
module Decoder3to8 (
   input  logic       E,
   input  logic [2:0] A,
   output logic [7:0] Y
);

   assign Y = E ? (8'b0000_0001 << A) : 8'b0000_0000;

endmodule

// File: rtl/rr_pick.sv
// rtl/rr_pick.sv - combinational round-robin first-one finder starting at ptr
module rr_pick #(
   parameter int N  = 4,
   parameter int PW = $clog2(N)
) (
   input  logic [N-1:0]  valid,
   input  logic [PW-1:0] ptr,
   output logic [PW-1:0] winner,
   output logic          found
);

   int          j;
   logic [PW-1:0] idx;

   always_comb begin
      winner = '0;
      found  = 1'b0;
      j      = 0;
      idx    = '0;
      for (int k = 0; k < N; k++) begin
         j = int'(ptr) + k;
         if (j >= N) j = j - N;
         idx = PW'(j);
         if (!found && valid[idx]) begin
            found  = 1'b1;
            winner = idx;
         end
      end
   end

endmodule

// File: rtl/regfile_wr_arbiter.sv
// rtl/regfile_wr_arbiter.sv - round-robin arbiter with burst lock for the register file write port
module regfile_wr_arbiter
   import regfile_arb_pkg::*;
#(
   parameter int NREQ      = 4,
   parameter int DATA_W    = 8,
   parameter int MAX_BURST = 4
) (
   input  logic                       clk,
   input  logic                       rst,
   input  logic [NREQ-1:0]            req_valid,
   input  logic [NREQ-1:0]            req_lock,
   input  logic [NREQ*REG_ADDR_W-1:0] req_addr,
   input  logic [NREQ*DATA_W-1:0]     req_data,
   output logic [NREQ-1:0]            req_ready,
   output logic                       wr_en,
   output logic [REG_ADDR_W-1:0]      wr_addr,
   output logic [DATA_W-1:0]          wr_data,
   output logic [7:0]                 wr_sel,
   output logic [$clog2(NREQ)-1:0]    grant_id
);

   localparam int PW = $clog2(NREQ);
   localparam int BW = $clog2(MAX_BURST + 1);

   arb_state_t    state, state_nxt;
   logic [PW-1:0] ptr, ptr_nxt, owner, owner_nxt, win, gidx;
   logic [BW-1:0] beats, beats_nxt;
   logic          found, xfer;

   function automatic logic [PW-1:0] next_idx(input logic [PW-1:0] i);
      return (i == PW'(NREQ - 1)) ? '0 : i + PW'(1);
   endfunction

   rr_pick #(.N(NREQ), .PW(PW)) u_pick (
      .valid  (req_valid),
      .ptr    (ptr),
      .winner (win),
      .found  (found)
   );

   // Reset masks the handshake so nothing is accepted while the block is being cleared.
   always_comb begin
      state_nxt = state;
      ptr_nxt   = ptr;
      owner_nxt = owner;
      beats_nxt = beats;
      req_ready = '0;
      xfer      = 1'b0;
      gidx      = win;
      if (!rst) begin
         case (state)
            ARB: begin
               if (found) begin
                  req_ready[win] = 1'b1;
                  xfer           = 1'b1;
                  ptr_nxt        = next_idx(win);
                  if (req_lock[win] && MAX_BURST > 1) begin
                     state_nxt = BURST;
                     owner_nxt = win;
                     beats_nxt = BW'(1);
                  end
               end
            end
            BURST: begin
               gidx = owner;
               if (req_valid[owner]) begin
                  req_ready[owner] = 1'b1;
                  xfer             = 1'b1;
                  beats_nxt        = beats + BW'(1);
                  if (!req_lock[owner] || (beats + BW'(1)) == BW'(MAX_BURST))
                     state_nxt = ARB;
               end else begin
                  state_nxt = ARB;
               end
            end
            default: state_nxt = ARB;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state    <= ARB;
         ptr      <= '0;
         owner    <= '0;
         beats    <= '0;
         wr_en    <= 1'b0;
         wr_addr  <= '0;
         wr_data  <= '0;
         grant_id <= '0;
      end else begin
         state <= state_nxt;
         ptr   <= ptr_nxt;
         owner <= owner_nxt;
         beats <= beats_nxt;
         wr_en <= xfer;
         if (xfer) begin
            wr_addr  <= req_addr[int'(gidx)*REG_ADDR_W +: REG_ADDR_W];
            wr_data  <= req_data[int'(gidx)*DATA_W +: DATA_W];
            grant_id <= gidx;
         end
      end
   end

   Decoder3to8 u_dec (
      .E (wr_en),
      .A (wr_addr),
      .Y (wr_sel)
   );

endmodule
